// File: rtl/env_intc.sv
// Vectored (IM2-style) interrupt controller for the tv80 test environment.
// Define ENV_INTC_LEVEL_EN to add the per-source LEVEL register at BASE_ADDR+5.
module env_intc #(
    parameter int unsigned NSRC      = 4,
    parameter logic [7:0]  BASE_ADDR = 8'hB0,
    parameter logic [7:0]  VEC_RESET = 8'hE0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            iorq_n,
    input  logic            m1_n,
    input  logic            rd_n,
    input  logic            wr_n,
    input  logic [7:0]      addr,
    input  logic [7:0]      d_out,
    input  logic [NSRC-1:0] irq_src,
    output logic            int_n,
    output logic [7:0]      di_out,
    output logic            di_oe
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DONE} state_e;

    localparam logic [7:0] OFF_MASK  = 8'd0;
    localparam logic [7:0] OFF_PEND  = 8'd1;
    localparam logic [7:0] OFF_ISR   = 8'd2;
    localparam logic [7:0] OFF_EOI   = 8'd3;
    localparam logic [7:0] OFF_VBASE = 8'd4;
`ifdef ENV_INTC_LEVEL_EN
    localparam logic [7:0] OFF_LEVEL = 8'd5;
    localparam logic [7:0] LAST_OFF  = 8'd5;
`else
    localparam logic [7:0] LAST_OFF  = 8'd4;
`endif

    state_e            state_q, state_d;
    logic [NSRC-1:0]   mask_q, mask_d;
    logic [NSRC-1:0]   pend_q, pend_d;
    logic [NSRC-1:0]   isr_q, isr_d;
    logic [NSRC-1:0]   src_q, src_d;
    logic [7:0]        vbase_q, vbase_d;
    logic [2:0]        ack_id_q, ack_id_d;
    logic              last_wr_q, last_wr_d;
    logic              int_n_q, int_n_d;
    logic [NSRC-1:0]   level;
`ifdef ENV_INTC_LEVEL_EN
    logic [NSRC-1:0]   level_q, level_d;
    assign level = level_q;
`else
    assign level = '0;
`endif

    logic [7:0]      offset;
    logic            reg_hit, wr_stb, wr_commit, cpu_ack, rd_hit, ack_drive;
    logic [NSRC-1:0] rise, eligible;
    logic            win_found, win_blocked, has_winner, eoi_found;
    logic [2:0]      win_id;
    logic [7:0]      rd_data, vector;

    // Offset arithmetic wraps mod 256, so one compare covers the whole window.
    assign offset    = addr - BASE_ADDR;
    assign reg_hit   = (offset <= LAST_OFF);
    assign wr_stb    = !iorq_n && !wr_n;
    // NOTE: a CPU write strobe spans several clocks; only its first edge commits.
    assign wr_commit = wr_stb && !last_wr_q;
    assign cpu_ack   = !m1_n && !iorq_n;
    assign rd_hit    = !iorq_n && !rd_n && m1_n && reg_hit;
    assign ack_drive = (state_q == S_ACK) && cpu_ack;
    assign rise      = irq_src & ~src_q;

    // Lowest-index eligible source wins unless an equal or higher priority is in service.
    always_comb begin
        eligible    = pend_q & mask_q;
        win_found   = 1'b0;
        win_id      = '0;
        win_blocked = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (!win_found && eligible[i]) begin
                win_found = 1'b1;
                win_id    = 3'(i);
            end
        end
        for (int i = 0; i < NSRC; i++) begin
            if (isr_q[i] && (3'(i) <= win_id)) win_blocked = 1'b1;
        end
        has_winner = win_found && !win_blocked;
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            OFF_MASK:  rd_data[NSRC-1:0] = mask_q;
            OFF_PEND:  rd_data[NSRC-1:0] = pend_q;
            OFF_ISR:   rd_data[NSRC-1:0] = isr_q;
            OFF_VBASE: rd_data           = vbase_q;
`ifdef ENV_INTC_LEVEL_EN
            OFF_LEVEL: rd_data[NSRC-1:0] = level_q;
`endif
            default:   rd_data = '0;
        endcase
        vector = vbase_q + {4'b0000, ack_id_q, 1'b0};
        di_oe  = rd_hit || ack_drive;
        di_out = ack_drive ? vector : (rd_hit ? rd_data : 8'h00);
    end

    always_comb begin
        mask_d    = mask_q;
        pend_d    = pend_q;
        isr_d     = isr_q;
        vbase_d   = vbase_q;
        src_d     = irq_src;
        last_wr_d = wr_stb;
        eoi_found = 1'b0;
`ifdef ENV_INTC_LEVEL_EN
        level_d   = level_q;
`endif
        if (wr_commit) begin
            case (offset)
                OFF_MASK:  mask_d  = d_out[NSRC-1:0];
                OFF_PEND:  pend_d  = pend_q & ~d_out[NSRC-1:0];
                OFF_VBASE: vbase_d = d_out;
`ifdef ENV_INTC_LEVEL_EN
                OFF_LEVEL: level_d = d_out[NSRC-1:0];
`endif
                OFF_EOI: begin
                    for (int i = 0; i < NSRC; i++) begin
                        if (!eoi_found && isr_q[i]) begin
                            isr_d[i]  = 1'b0;
                            eoi_found = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        // EOI above saw the pre-DONE ISR; the DONE set lands on top of it.
        if (state_q == S_DONE) begin
            for (int i = 0; i < NSRC; i++) begin
                if (ack_id_q == 3'(i)) begin
                    isr_d[i] = 1'b1;
                    if (!level[i]) pend_d[i] = 1'b0;
                end
            end
        end
        pend_d = pend_d | rise;
        pend_d = (pend_d & ~level) | (irq_src & level);
    end

    always_comb begin
        state_d  = state_q;
        ack_id_d = ack_id_q;
        case (state_q)
            S_IDLE: if (has_winner) state_d = S_REQ;
            S_REQ: begin
                if (!has_winner) begin
                    state_d = S_IDLE;
                end else if (cpu_ack) begin
                    state_d  = S_ACK;
                    ack_id_d = win_id;
                end
            end
            S_ACK:   if (!cpu_ack) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // NOTE: int_n is decoded from the next state so the flop tracks the state register exactly.
        int_n_d = (state_d != S_REQ);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mask_q    <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
            src_q     <= '0;
            vbase_q   <= VEC_RESET;
            ack_id_q  <= '0;
            last_wr_q <= 1'b0;
            int_n_q   <= 1'b1;
`ifdef ENV_INTC_LEVEL_EN
            level_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
            src_q     <= src_d;
            vbase_q   <= vbase_d;
            ack_id_q  <= ack_id_d;
            last_wr_q <= last_wr_d;
            int_n_q   <= int_n_d;
`ifdef ENV_INTC_LEVEL_EN
            level_q   <= level_d;
`endif
        end
    end

    assign int_n = int_n_q;

endmodule

// File: doc/env_intc.md
Name: env_intc

Overview:
- Vectored (IM2-style) interrupt controller for the tv80 test environment.
- Collects NSRC interrupt sources from bench models, prioritises them and drives the CPU's int_n.
- Supplies the vector byte during the interrupt-acknowledge cycle (M1 and IORQ both low).
- Exposes mask, pending, in-service and EOI registers on the env I/O port space, so test programs can sequence interrupts without bench-side countdown hacks.

Parameters:
- NSRC, 4, number of interrupt sources (1..8). Bit 0 has the highest priority.
- BASE_ADDR, 8'hB0, I/O address of register 0. Registers occupy BASE_ADDR+0 .. BASE_ADDR+5.
- VEC_RESET, 8'hE0, reset value of the vector base register.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, synchronous active-low reset.
- iorq_n, input, 1, CPU IORQ, active low.
- m1_n, input, 1, CPU M1, active low.
- rd_n, input, 1, CPU RD, active low.
- wr_n, input, 1, CPU WR, active low.
- addr, input, 8, CPU address bits [7:0].
- d_out, input, 8, CPU write data.
- irq_src, input, NSRC, interrupt source lines, active high.
- int_n, output, 1, interrupt request to CPU, active low.
- di_out, output, 8, read or vector data toward CPU DI.
- di_oe, output, 1, high when di_out must drive DI. The bench tristates DI when low.

Behaviour:
- Register map (offsets from BASE_ADDR):
  - +0 MASK, RW, 1 = enabled, reset 0.
  - +1 PEND, R; write 1 to clear a bit.
  - +2 ISR, R (in-service).
  - +3 EOI, W; any value clears the highest-priority set ISR bit.
  - +4 VBASE, RW, reset VEC_RESET.
  - +5 LEVEL, see Optional Feature.
- Reads of bits at or above NSRC return 0.
- Write commit: wr_stb = !iorq_n & !wr_n, registered as last_wr. A write commits exactly once, on the edge where wr_stb=1 and last_wr=0, using addr and d_out sampled at that edge.
- Register read: combinational. di_oe=1 and di_out=register whenever !iorq_n & !rd_n & m1_n and addr is in BASE_ADDR..BASE_ADDR+5. Otherwise the register-read path is idle.
- Edge detect: irq_src is registered as src_q. A rising edge (irq_src & ~src_q) sets the matching PEND bit on the next clk.
- Eligibility: eligible = PEND & MASK. A source wins if it is the lowest-index eligible bit AND no ISR bit of equal or lower index is set (priority nesting).
- FSM states:
  - IDLE: int_n=1. Go to REQ when a winner exists.
  - REQ: int_n=0.
    - Winner disappears (masked or cleared) → IDLE; int_n=1 on the next clk.
    - !m1_n & !iorq_n → ACK. Latch the current winner as ack_id; later higher-priority arrivals do not change ack_id.
  - ACK: di_oe=1, di_out = VBASE + {ack_id,1'b0} (8-bit wrap), combinational while !m1_n & !iorq_n.
    - When m1_n or iorq_n rises → DONE.
  - DONE: one cycle. Set ISR[ack_id], clear PEND[ack_id], int_n=1, → IDLE.
- int_n is registered and reflects the state after each clk edge.
- Minimum gap between successive int_n assertions: 2 clk (DONE, IDLE).
- Simultaneous events:
  - Rising edge on source k in the same cycle as a W1C of PEND[k] or DONE clearing PEND[k]: the set wins, PEND[k]=1.
  - EOI with ISR==0: no effect.
  - EOI and DONE in the same cycle: EOI is evaluated on the pre-DONE ISR, then the DONE set is applied.
- Reset (reset_n=0 at a clk edge, including mid-ACK):
  - MASK=0, PEND=0, ISR=0, VBASE=VEC_RESET, src_q=0, last_wr=0, state=IDLE, int_n=1.
  - di_oe is 0 unless a register read is in progress.

Optional Feature:
- Macro: ENV_INTC_LEVEL_EN.
- When defined:
  - LEVEL register at +5 is RW, reset 0. LEVEL[k]=1 makes source k level-sensitive: PEND[k] = irq_src[k] each cycle.
  - W1C on a level bit has no effect while the source is high.
  - DONE does not clear PEND for level sources.
  - The source must drop before EOI, otherwise it re-requests.
- When undefined:
  - All sources are edge-sensitive.
  - +5 is not decoded: reads give di_oe=0, writes are ignored.

Test Plan:
- Reset: MASK=0, pulse irq_src[2] → PEND=8'h04, int_n stays 1. Write MASK=8'h04 → int_n=0 within 2 clk.
- Vector: VBASE=8'h40, source 2 pending, CPU ack cycle → di_out=8'h44 with di_oe=1. After ack, ISR=8'h04, PEND=0, int_n=1.
- Priority and nesting: ISR=8'h04, source 3 pends → int_n stays 1. Source 1 pends → int_n=0, vector for id 1. EOI ×2 → ISR=0 → source 3 requests.
- Withdrawal and race: in REQ, write MASK=0 → int_n=1 next clk, state IDLE. Rising edge of source 0 in the same cycle as PEND W1C of bit 0 → PEND[0]=1.
- Reset mid-ACK with reset_n=0 → int_n=1, ISR=0, PEND=0, di_oe=0 after the edge.
- (ENV_INTC_LEVEL_EN) LEVEL=8'h01, hold irq_src[0]=1 through ack and EOI → second request. Drop the source, then EOI → int_n stays 1.
